// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared constants for the PS/2 mouse packet receiver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  // Frame FSM state encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_DATA = 2'd1;
  localparam logic [1:0] c_ST_PAR  = 2'd2;
  localparam logic [1:0] c_ST_STOP = 2'd3;

  localparam int PKT_BYTES_STD   = 3;
  localparam int PKT_BYTES_WHEEL = 4;

  // Byte 0 field positions
  localparam int c_B0_ALWAYS1 = 3;
  localparam int c_B0_XSIGN   = 4;
  localparam int c_B0_YSIGN   = 5;
  localparam int c_B0_XOVF    = 6;
  localparam int c_B0_YOVF    = 7;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module  : ps2_frame_rx
// Brief   : PS/2 line synchronizer, 11-bit frame FSM and inactivity timeout.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  input  logic       i_busy,
  output logic [7:0] o_byte,
  output logic       o_byte_ok,
  output logic       o_frame_err
);

  localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_last;
  logic [1:0]             r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [c_TMO_W-1:0]     r_tmo_cnt;
  logic                   w_fe;
  logic                   w_dat;
  logic                   w_active;

  assign w_fe     = r_clk_last & ~r_clk_sync[SYNC_STAGES-1];
  assign w_dat    = r_dat_sync[SYNC_STAGES-1];
  assign w_active = (r_state != c_ST_IDLE) | i_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_last <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_clk_last <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tmo_cnt   <= '0;
      o_byte      <= '0;
      o_byte_ok   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_byte_ok   <= 1'b0;
      o_frame_err <= 1'b0;
      if (w_fe) begin
        // Any clock edge proves the device is alive, so errors and timeout never coincide
        r_tmo_cnt <= '0;
        case (r_state)
          c_ST_IDLE: begin
            if (!w_dat) begin
              r_state   <= c_ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          c_ST_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= c_ST_PAR;
          end
          c_ST_PAR: begin
            if (odd_parity_ok(r_shift, w_dat)) begin
              r_state <= c_ST_STOP;
            end else begin
              r_state     <= c_ST_IDLE;
              o_frame_err <= 1'b1;
            end
          end
          c_ST_STOP: begin
            r_state <= c_ST_IDLE;
            if (w_dat) begin
              o_byte    <= r_shift;
              o_byte_ok <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          default: r_state <= c_ST_IDLE;
        endcase
      end else if (w_active) begin
        if (r_tmo_cnt == c_TMO_LAST) begin
          r_tmo_cnt   <= '0;
          r_state     <= c_ST_IDLE;
          o_frame_err <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_packet_rx.sv
// ============================================================================
// Module  : ps2_packet_rx
// Brief   : PS/2 mouse packet decoder with clamped cursor accumulation.
//           Optional wheel byte enabled by defining PS2_WHEEL_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_packet_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000,
  parameter int POS_W       = 11,
  parameter int XMAX        = 639,
  parameter int YMAX        = 479
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    M_CLK,
  inout  wire                     M_Dat,
  output logic                    pkt_valid,
  output logic [2:0]              btn,
  output logic signed [8:0]       dx,
  output logic signed [8:0]       dy,
  output logic signed [3:0]       dz,
  output logic [POS_W-1:0]        pos_x,
  output logic [POS_W-1:0]        pos_y,
  output logic                    frame_err,
  output logic                    ovf
);

`ifdef PS2_WHEEL_EN
  localparam int c_N = PKT_BYTES_WHEEL;
`else
  localparam int c_N = PKT_BYTES_STD;
`endif
  localparam logic [1:0]              c_LAST_IDX = 2'(c_N - 1);
  localparam int                      c_SW       = POS_W + 2;
  localparam logic signed [c_SW-1:0]  c_XLIM     = c_SW'(XMAX);
  localparam logic signed [c_SW-1:0]  c_YLIM     = c_SW'(YMAX);
  localparam logic [POS_W-1:0]        c_X0       = POS_W'(XMAX / 2);
  localparam logic [POS_W-1:0]        c_Y0       = POS_W'(YMAX / 2);

  logic [7:0]              w_byte;
  logic                    w_byte_ok;
  logic                    w_rx_err;
  logic [1:0]              r_idx;
  logic [7:0]              r_b0;
  logic [7:0]              r_b1;
  logic [7:0]              w_b2;
  logic                    w_realign;
  logic                    w_pkt_done;
  logic signed [8:0]       w_dx;
  logic signed [8:0]       w_dy;
  logic                    w_ovf;
  logic signed [c_SW-1:0]  w_sum_x;
  logic signed [c_SW-1:0]  w_sum_y;

  // M_Dat is an open-collector line owned by the device; this block only listens.
  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .i_ps2_clk   (M_CLK),
    .i_ps2_dat   (M_Dat),
    .i_busy      (r_idx != 2'd0),
    .o_byte      (w_byte),
    .o_byte_ok   (w_byte_ok),
    .o_frame_err (w_rx_err)
  );

`ifdef PS2_WHEEL_EN
  logic [7:0] r_b2;
  assign w_b2 = r_b2;
`else
  assign w_b2 = w_byte;
`endif

  assign w_realign  = w_byte_ok & (r_idx == 2'd0) & ~w_byte[c_B0_ALWAYS1];
  assign w_pkt_done = w_byte_ok & (r_idx == c_LAST_IDX);
  assign w_dx       = {r_b0[c_B0_XSIGN], r_b1};
  assign w_dy       = {r_b0[c_B0_YSIGN], w_b2};
  assign w_ovf      = r_b0[c_B0_XOVF] | r_b0[c_B0_YOVF];
  assign w_sum_x    = $signed({2'b00, pos_x}) + c_SW'(w_dx);
  // Screen Y grows downward while the mouse reports up as positive
  assign w_sum_y    = $signed({2'b00, pos_y}) - c_SW'(w_dy);

  function automatic logic [POS_W-1:0] clamp(input logic signed [c_SW-1:0] v,
                                             input logic signed [c_SW-1:0] lim);
    if (v[c_SW-1])  return '0;
    else if (v > lim) return lim[POS_W-1:0];
    else              return v[POS_W-1:0];
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_idx     <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
`ifdef PS2_WHEEL_EN
      r_b2      <= '0;
`endif
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      btn       <= '0;
      dx        <= '0;
      dy        <= '0;
      ovf       <= 1'b0;
      pos_x     <= c_X0;
      pos_y     <= c_Y0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= w_rx_err | w_realign;
      if (w_rx_err || w_realign) begin
        r_idx <= '0;
      end else if (w_pkt_done) begin
        r_idx     <= '0;
        pkt_valid <= 1'b1;
        btn       <= r_b0[2:0];
        dx        <= w_dx;
        dy        <= w_dy;
        ovf       <= w_ovf;
        if (!w_ovf) begin
          pos_x <= clamp(w_sum_x, c_XLIM);
          pos_y <= clamp(w_sum_y, c_YLIM);
        end
      end else if (w_byte_ok) begin
        case (r_idx)
          2'd0:    r_b0 <= w_byte;
          2'd1:    r_b1 <= w_byte;
`ifdef PS2_WHEEL_EN
          2'd2:    r_b2 <= w_byte;
`endif
          default: ;
        endcase
        r_idx <= r_idx + 2'd1;
      end
    end
  end

`ifdef PS2_WHEEL_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)          dz <= '0;
    else if (w_pkt_done) dz <= w_byte[3:0];
  end
`else
  assign dz = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_packet_rx.sv
// ============================================================================
// Module  : tb_ps2_packet_rx
// Brief   : Self-checking bench for ps2_packet_rx; honours PS2_WHEEL_EN.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_packet_rx;

  localparam int c_TMO  = 500;
  localparam int c_HALF = 8;
  localparam int c_XMAX = 639;
  localparam int c_YMAX = 479;
`ifdef PS2_WHEEL_EN
  localparam bit c_WHEEL = 1'b1;
`else
  localparam bit c_WHEEL = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_clk = 1'b1;
  logic r_dat = 1'b1;
  wire  m_dat;
  assign m_dat = r_dat;

  logic              pkt_valid, frame_err, ovf;
  logic [2:0]        btn;
  logic signed [8:0] dx, dy;
  logic signed [3:0] dz;
  logic [10:0]       pos_x, pos_y;

  ps2_packet_rx #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (c_TMO),
    .POS_W       (11),
    .XMAX        (c_XMAX),
    .YMAX        (c_YMAX)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .M_CLK     (m_clk),
    .M_Dat     (m_dat),
    .pkt_valid (pkt_valid),
    .btn       (btn),
    .dx        (dx),
    .dy        (dy),
    .dz        (dz),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .frame_err (frame_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  btn;
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic [3:0]  dz;
    logic        ovf;
    logic [10:0] px;
    logic [10:0] py;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pv_cnt = 0;
  int mx = c_XMAX / 2;
  int my = c_YMAX / 2;

  // Scoreboard side: pop one expectation per pkt_valid pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (pkt_valid) begin
        pv_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pkt: pkt_valid with empty scoreboard");
        end else begin
          m_e = q.pop_front();
          checks += 6;
          if (btn !== m_e.btn)  begin errors++; $display("FAIL pkt_btn got %0h exp %0h", btn, m_e.btn); end
          if (dx !== m_e.dx)    begin errors++; $display("FAIL pkt_dx got %0h exp %0h", dx, m_e.dx); end
          if (dy !== m_e.dy)    begin errors++; $display("FAIL pkt_dy got %0h exp %0h", dy, m_e.dy); end
          if (dz !== m_e.dz)    begin errors++; $display("FAIL pkt_dz got %0h exp %0h", dz, m_e.dz); end
          if (ovf !== m_e.ovf)  begin errors++; $display("FAIL pkt_ovf got %0b exp %0b", ovf, m_e.ovf); end
          if (pos_x !== m_e.px || pos_y !== m_e.py) begin
            errors++;
            $display("FAIL pkt_pos got %0d,%0d exp %0d,%0d", pos_x, pos_y, m_e.px, m_e.py);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    exp_t e;
    int vx, vy;
    vx = b0[4] ? int'(b1) - 256 : int'(b1);
    vy = b0[5] ? int'(b2) - 256 : int'(b2);
    e.btn = b0[2:0];
    e.dx  = 9'(vx);
    e.dy  = 9'(vy);
    e.dz  = c_WHEEL ? b3[3:0] : 4'h0;
    e.ovf = b0[6] | b0[7];
    if (!e.ovf) begin
      mx = mx + vx;
      my = my - vy;
      if (mx < 0) mx = 0;
      if (mx > c_XMAX) mx = c_XMAX;
      if (my < 0) my = 0;
      if (my > c_YMAX) my = c_YMAX;
    end
    e.px = 11'(mx);
    e.py = 11'(my);
    q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    r_dat = b;
    repeat (c_HALF) @(negedge clk);
    m_clk = 1'b0;
    repeat (c_HALF) @(negedge clk);
    m_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    r_dat = 1'b1;
    repeat (2 * c_HALF) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    push_exp(b0, b1, b2, b3);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    if (c_WHEEL) send_byte(b3, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks += 3;
    if (pkt_valid !== 1'b0 || frame_err !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_flags got pv=%0b fe=%0b ovf=%0b exp 0", pkt_valid, frame_err, ovf);
    end
    if (btn !== 3'd0 || dx !== 9'd0 || dy !== 9'd0 || dz !== 4'd0) begin
      errors++; $display("FAIL reset_fields got btn=%0h dx=%0h dy=%0h dz=%0h exp 0", btn, dx, dy, dz);
    end
    if (pos_x !== 11'd319 || pos_y !== 11'd239) begin
      errors++; $display("FAIL reset_pos got %0d,%0d exp 319,239", pos_x, pos_y);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_pkt(8'h08, 8'h05, 8'h03, 8'h00);
    checks += 3;
    if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL basic_pv got %0d exp %0d", pv_cnt, pv0 + 1); end
    if (fe_cnt !== fe0)     begin errors++; $display("FAIL basic_fe got %0d exp %0d", fe_cnt, fe0); end
    if (pos_x !== 11'd324 || pos_y !== 11'd236) begin
      errors++; $display("FAIL basic_pos got %0d,%0d exp 324,236", pos_x, pos_y);
    end
  endtask

  task automatic test_parity();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    repeat (10) @(negedge clk);
    checks += 2;
    if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL parity_fe got %0d exp %0d", fe_cnt, fe0 + 1); end
    if (pv_cnt !== pv0)     begin errors++; $display("FAIL parity_nopv got %0d exp %0d", pv_cnt, pv0); end
    send_pkt(8'h08, 8'h05, 8'h03, 8'h00);
    checks++;
    if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL parity_recover got %0d exp %0d", pv_cnt, pv0 + 1); end
  endtask

  task automatic test_realign();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL realign_fe got %0d exp %0d", fe_cnt, fe0 + 1); end
    send_pkt(8'h09, 8'h02, 8'h01, 8'h00);
    checks++;
    if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL realign_pv got %0d exp %0d", pv_cnt, pv0 + 1); end
  endtask

  task automatic test_timeout();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    r_dat = 1'b1;
    repeat (c_TMO - 100) @(negedge clk);
    checks++;
    if (fe_cnt !== fe0) begin errors++; $display("FAIL timeout_early got %0d exp %0d", fe_cnt, fe0); end
    repeat (150) @(negedge clk);
    checks++;
    if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL timeout_fe got %0d exp %0d", fe_cnt, fe0 + 1); end
    send_pkt(8'h28, 8'h10, 8'hF0, 8'h00);
    checks++;
    if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL timeout_recover got %0d exp %0d", pv_cnt, pv0 + 1); end
  endtask

  task automatic test_back_to_back();
    int pv0;
    pv0 = pv_cnt;
    send_pkt(8'h2F, 8'h7F, 8'hF0, 8'h01);
    send_pkt(8'h0B, 8'h80, 8'h00, 8'h0E);
    send_pkt(8'h38, 8'hFF, 8'hFF, 8'h00);
    checks++;
    if (pv_cnt !== pv0 + 3) begin errors++; $display("FAIL b2b_pv got %0d exp %0d", pv_cnt, pv0 + 3); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 5; i++) send_pkt(8'h18, 8'h00, 8'h00, 8'h00);
    checks++;
    if (pos_x !== 11'd0) begin errors++; $display("FAIL clamp_x got %0d exp 0", pos_x); end
    send_pkt(8'h48, 8'h10, 8'h10, 8'h00);
    checks += 2;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", ovf); end
    if (pos_x !== 11'd0 || pos_y !== 11'(my)) begin
      errors++; $display("FAIL ovf_hold got %0d,%0d exp 0,%0d", pos_x, pos_y, my);
    end
  endtask

`ifdef PS2_WHEEL_EN
  task automatic test_wheel();
    send_pkt(8'h09, 8'h00, 8'h00, 8'h0F);
    checks += 2;
    if (btn !== 3'd1)  begin errors++; $display("FAIL wheel_btn got %0h exp 1", btn); end
    if (dz !== -4'sd1) begin errors++; $display("FAIL wheel_dz got %0h exp f", dz); end
  endtask
`endif

  task automatic test_reset_midframe();
    int pv0;
    send_byte(8'h08, 1'b0);
    send_byte(8'h07, 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    rst_n = 1'b0;
    r_dat = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (pkt_valid !== 1'b0 || frame_err !== 1'b0 || ovf !== 1'b0 || btn !== 3'd0 ||
        dx !== 9'd0 || dy !== 9'd0 || dz !== 4'd0) begin
      errors++; $display("FAIL midrst_fields got pv=%0b fe=%0b btn=%0h dx=%0h dy=%0h exp 0",
                         pkt_valid, frame_err, btn, dx, dy);
    end
    if (pos_x !== 11'd319 || pos_y !== 11'd239) begin
      errors++; $display("FAIL midrst_pos got %0d,%0d exp 319,239", pos_x, pos_y);
    end
    mx = c_XMAX / 2;
    my = c_YMAX / 2;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pv0 = pv_cnt;
    send_pkt(8'h0C, 8'h0A, 8'h14, 8'h03);
    checks++;
    if (pv_cnt !== pv0 + 1) begin errors++; $display("FAIL midrst_recover got %0d exp %0d", pv_cnt, pv0 + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_realign();
    test_timeout();
    test_back_to_back();
    test_clamp();
`ifdef PS2_WHEEL_EN
    test_wheel();
`endif
    test_reset_midframe();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
